// File: rtl/io_checkpoint_sequencer.sv
// io_checkpoint_sequencer: watches a status bus for an ordered sequence of
// masked patterns. Each step must match for STABLE consecutive cycles before
// a per-step timeout expires. Reports pass/fail, current step and failing step.
module io_checkpoint_sequencer #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  parameter  int TO_W   = 24,
  parameter  int STABLE = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [DATA_W-1:0] cfg_pattern,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic [AW:0]       num_steps,
  input  logic [TO_W-1:0]   timeout_cycles,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] watch_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [AW:0]       step_o,
  output logic              step_pulse_o
);

  localparam int SW = $clog2(STABLE + 1);
  localparam logic [SW-1:0] P_STAB_LAST = SW'(STABLE - 1);
  localparam logic [AW:0]   P_DEPTH     = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] pat;
    logic [DATA_W-1:0] msk;
  } entry_t;

  entry_t            r_tbl [DEPTH];
  state_t            r_state, w_state_nxt;
  logic [AW:0]       r_step, r_num;
  logic [SW-1:0]     r_stab;
  logic [TO_W-1:0]   r_to, r_tlim;
  logic              r_pass, r_tmo, r_pulse;

  logic              w_run, w_match, w_accept, w_last, w_tmo_hit;
  logic [AW:0]       w_num_clamp;
  entry_t            w_cur;

  // Current table entry and per-cycle compare/event decode
  always_comb begin
    w_run       = (r_state == S_RUN);
    w_cur       = r_tbl[r_step[AW-1:0]];
    w_match     = (((watch_i ^ w_cur.pat) & w_cur.msk) == '0);
    w_accept    = w_run && w_match && (r_stab == P_STAB_LAST);
    w_last      = (r_step == r_num - 1'b1);
    // Acceptance wins over a timeout landing on the same cycle
    w_tmo_hit   = w_run && !w_accept && (r_tlim != '0) && (r_to == r_tlim - 1'b1);
    w_num_clamp = (num_steps > P_DEPTH) ? P_DEPTH : num_steps;
  end

  // Sequence table: writable only while no run is in progress, never reset
  always_ff @(posedge wb_clk_i) begin
    if (cfg_we && !w_run) r_tbl[cfg_addr] <= '{pat: cfg_pattern, msk: cfg_mask};
  end

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state; abort overrides start and every RUN event
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) w_state_nxt = (w_num_clamp == '0) ? S_DONE : S_RUN;
        S_RUN:          if ((w_accept && w_last) || w_tmo_hit) w_state_nxt = S_DONE;
        default:        w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Step/debounce/timeout counters and registered status flags
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_step  <= '0;
      r_num   <= '0;
      r_stab  <= '0;
      r_to    <= '0;
      r_tlim  <= '0;
      r_pass  <= 1'b0;
      r_tmo   <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (abort) begin
        r_step <= '0;
        r_stab <= '0;
        r_to   <= '0;
        r_pass <= 1'b0;
        r_tmo  <= 1'b0;
      end else if (!w_run) begin
        if (start) begin
          r_num  <= w_num_clamp;
          r_tlim <= timeout_cycles;
          r_step <= '0;
          r_stab <= '0;
          r_to   <= '0;
          r_pass <= (w_num_clamp == '0);
          r_tmo  <= 1'b0;
        end
      end else if (w_accept) begin
        r_pulse <= 1'b1;
        r_step  <= r_step + 1'b1;
        r_stab  <= '0;
        r_to    <= '0;
        if (w_last) r_pass <= 1'b1;
      end else begin
        r_stab <= w_match ? r_stab + 1'b1 : '0;
        if (r_to != '1) r_to <= r_to + 1'b1;
        if (w_tmo_hit) r_tmo <= 1'b1;
      end
    end
  end

  // Outputs: all taken straight from registers
  always_comb begin
    busy_o       = (r_state == S_RUN);
    done_o       = (r_state == S_DONE);
    pass_o       = r_pass;
    timeout_o    = r_tmo;
    step_o       = r_step;
    step_pulse_o = r_pulse;
  end

endmodule

// File: tb/tb_io_checkpoint_sequencer.sv
// Bench for io_checkpoint_sequencer: directed scenarios plus randomized
// traffic, every cycle compared against a step/run-length reference model.
module tb_io_checkpoint_sequencer;
  localparam int DATA_W = 16, DEPTH = 8, TO_W = 24, STABLE = 4, AW = 3;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [DATA_W-1:0] cfg_pattern, cfg_mask;
  logic [AW:0]       num_steps;
  logic [TO_W-1:0]   timeout_cycles;
  logic              start, abort;
  logic [DATA_W-1:0] watch_i;
  logic              busy_o, done_o, pass_o, timeout_o, step_pulse_o;
  logic [AW:0]       step_o;

  always #5 wb_clk_i = ~wb_clk_i;

  io_checkpoint_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TO_W(TO_W), .STABLE(STABLE)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .num_steps(num_steps),
    .timeout_cycles(timeout_cycles), .start(start), .abort(abort), .watch_i(watch_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .step_o(step_o), .step_pulse_o(step_pulse_o)
  );

  int errs = 0, checks = 0, npulse = 0;

  // Reference model: a run is "in progress" with a step index, the length of
  // the current streak of matching samples and the cycles spent on the step.
  bit                m_busy, m_done, m_pass, m_tmo, m_pulse;
  int                m_step, m_streak, m_elapsed, m_n, m_lim;
  logic [DATA_W-1:0] tp [DEPTH];
  logic [DATA_W-1:0] tm [DEPTH];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit was_busy;
    bit hit;
    was_busy = m_busy;
    m_pulse  = 0;
    if (cfg_we && !was_busy) begin
      tp[cfg_addr] = cfg_pattern;
      tm[cfg_addr] = cfg_mask;
    end
    if (wb_rst_i) begin
      m_busy = 0; m_done = 0; m_pass = 0; m_tmo = 0; m_step = 0;
      m_streak = 0; m_elapsed = 0;
    end else if (abort) begin
      m_busy = 0; m_done = 0; m_pass = 0; m_tmo = 0; m_step = 0;
      m_streak = 0; m_elapsed = 0;
    end else if (!was_busy) begin
      if (start) begin
        m_n = (int'(num_steps) > DEPTH) ? DEPTH : int'(num_steps);
        m_lim = int'(timeout_cycles);
        m_step = 0; m_streak = 0; m_elapsed = 0; m_tmo = 0;
        if (m_n == 0) begin m_done = 1; m_pass = 1; end
        else begin m_busy = 1; m_done = 0; m_pass = 0; end
      end
    end else begin
      hit = (((watch_i ^ tp[m_step]) & tm[m_step]) == '0);
      m_streak = hit ? m_streak + 1 : 0;
      m_elapsed++;
      if (m_streak == STABLE) begin
        m_pulse = 1; m_step++; m_streak = 0; m_elapsed = 0;
        if (m_step == m_n) begin m_busy = 0; m_done = 1; m_pass = 1; end
      end else if (m_lim != 0 && m_elapsed == m_lim) begin
        m_busy = 0; m_done = 1; m_tmo = 1;
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge wb_clk_i); #1;
    if (step_pulse_o) npulse++;
    chk("busy",  busy_o,       m_busy);
    chk("done",  done_o,       m_done);
    chk("pass",  pass_o,       m_pass);
    chk("tmo",   timeout_o,    m_tmo);
    chk("step",  step_o,       m_step);
    chk("pulse", step_pulse_o, m_pulse);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(int a, logic [DATA_W-1:0] p, logic [DATA_W-1:0] m);
    cfg_we = 1; cfg_addr = AW'(a); cfg_pattern = p; cfg_mask = m;
    tick();
    cfg_we = 0;
  endtask

  task automatic go(int n, int lim);
    num_steps = (AW + 1)'(n); timeout_cycles = TO_W'(lim); start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    wb_rst_i = 1; cfg_we = 0; cfg_addr = '0; cfg_pattern = '0; cfg_mask = '0;
    num_steps = '0; timeout_cycles = '0; start = 0; abort = 0; watch_i = '0;
    for (int i = 0; i < DEPTH; i++) begin tp[i] = '0; tm[i] = '0; end

    // Reset state
    ticks(2);
    chk("rst_busy", busy_o, 0); chk("rst_done", done_o, 0);
    chk("rst_step", step_o, 0); chk("rst_pass", pass_o, 0);
    wb_rst_i = 0;
    tick();

    // Two-step exact sequence
    wr(0, 16'hAB60, 16'hFFFF); wr(1, 16'hAB61, 16'hFFFF);
    go(2, 1000);
    npulse = 0;
    watch_i = 16'hAB60; ticks(4);
    chk("s1_pulse0", npulse, 1); chk("s1_step1", step_o, 1);
    watch_i = 16'hAB61; ticks(3);
    chk("s1_not_done_yet", done_o, 0);
    tick();
    chk("s1_done", done_o, 1); chk("s1_pass", pass_o, 1);
    chk("s1_step", step_o, 2); chk("s1_npulse", npulse, 2); chk("s1_busy", busy_o, 0);

    // Glitch restarts debounce, then abort at step 1
    go(2, 1000);
    npulse = 0;
    watch_i = 16'hAB60; ticks(3);
    watch_i = 16'h0000; tick();
    watch_i = 16'hAB60; ticks(3);
    chk("s2_no_early", npulse, 0);
    tick();
    chk("s2_accept", npulse, 1); chk("s2_step1", step_o, 1);
    watch_i = 16'h0000; ticks(2);
    abort = 1; tick(); abort = 0;
    chk("s2_ab_busy", busy_o, 0); chk("s2_ab_done", done_o, 0); chk("s2_ab_step", step_o, 0);

    // Table write during RUN is ignored
    go(1, 0);
    wr(0, 16'h1234, 16'hFFFF);
    watch_i = 16'hAB60; ticks(4);
    chk("s3_done", done_o, 1); chk("s3_pass", pass_o, 1);

    // Masked zero check on bits [7:2]
    wr(0, 16'h0000, 16'h00FC);
    watch_i = 16'hFF03;
    go(1, 0);
    ticks(3);
    chk("s4_not_yet", done_o, 0);
    tick();
    chk("s4_done", done_o, 1); chk("s4_pass", pass_o, 1);

    // Timeout after 50 cycles
    watch_i = 16'h5555;
    go(2, 50);
    ticks(49);
    chk("s5_pre", done_o, 0);
    tick();
    chk("s5_done", done_o, 1); chk("s5_tmo", timeout_o, 1);
    chk("s5_pass", pass_o, 0); chk("s5_step", step_o, 0);

    // Zero-length sequence
    go(0, 0);
    chk("s6_done", done_o, 1); chk("s6_pass", pass_o, 1); chk("s6_busy", busy_o, 0);

    // Length clamped to DEPTH
    for (int i = 0; i < DEPTH; i++) wr(i, 16'hFFFF, 16'h0000);
    npulse = 0;
    go(12, 0);
    ticks(8 * STABLE - 1);
    chk("s7_pre", done_o, 0);
    tick();
    chk("s7_npulse", npulse, 8); chk("s7_step", step_o, 8); chk("s7_pass", pass_o, 1);

    // Reset mid-run
    wr(0, 16'h0001, 16'hFFFF);
    watch_i = 16'h0000;
    go(3, 0);
    ticks(3);
    wb_rst_i = 1; tick(); wb_rst_i = 0;
    chk("s8_busy", busy_o, 0); chk("s8_step", step_o, 0);

    // Randomized traffic
    for (int i = 0; i < DEPTH; i++) wr(i, 16'($urandom), 16'($urandom & $urandom));
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 999);
      cfg_we = 0; start = 0; abort = 0; wb_rst_i = 0;
      if (r < 25) begin
        cfg_we = 1; cfg_addr = AW'($urandom_range(0, DEPTH - 1));
        cfg_pattern = 16'($urandom); cfg_mask = 16'($urandom & $urandom);
      end else if (r < 55) begin
        start = 1; num_steps = (AW + 1)'($urandom_range(0, 12));
        timeout_cycles = ($urandom_range(0, 3) == 0) ? '0 : TO_W'($urandom_range(1, 40));
      end else if (r < 60) abort = 1;
      else if (r < 62) wb_rst_i = 1;
      if (m_busy && $urandom_range(0, 4) != 0)
        watch_i = tp[m_step] ^ (16'($urandom) & ~tm[m_step]);
      else
        watch_i = 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
